race_controller: RTL and testbench

Sequences one race around the lap timing datapath. It runs a 3-2-1-GO start countdown, issues the single-cycle start and stop strobes that drive the lap timer, and qualifies raw lap-line crossings with a hold-off window. It counts completed laps and ends the race after a configurable lap count. It sits between the track/car logic and the lap timer, all on pclk.

---
 rtl/race_pkg.sv | 20 ++
 rtl/race_controller_if.sv | 32 +++
 rtl/rc_holdoff.sv | 42 ++++
 rtl/race_controller.sv | 160 ++++++++++++++++
 tb/tb_race_controller.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/race_pkg.sv
// Shared types and constants for the race sequencer.
// Holds the FSM state encoding, countdown start value and lap counter width.
package race_pkg;

  localparam int STATE_W = 2;
  localparam int LAP_W = 4;
  localparam logic [1:0] CD_START = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACING    = 2'd2,
    FINISHED  = 2'd3
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/race_controller_if.sv
// Track-side inputs and lap-timer-side outputs of the race sequencer.
// The master drives the race inputs; the slave (race_controller) drives the status and strobes.
interface race_controller_if;
  import race_pkg::*;

  logic               race_req;
  logic               abort;
  logic               lap_line;
  logic               throttle;
  logic               start;
  logic               stop;
  logic               lap_finished;
  logic [1:0]         countdown;
  logic               go_light;
  logic [LAP_W-1:0]   lap_count;
  logic               race_over;
  logic               false_start;
  logic [STATE_W-1:0] state;

  modport master (
    output race_req, abort, lap_line, throttle,
    input  start, stop, lap_finished, countdown, go_light, lap_count,
           race_over, false_start, state
  );

  modport slave (
    input  race_req, abort, lap_line, throttle,
    output start, stop, lap_finished, countdown, go_light, lap_count,
           race_over, false_start, state
  );

endinterface

// File: rtl/rc_holdoff.sv
// Lap-line qualifier: accepts a crossing only when the hold-off counter is idle, then reloads it.
// accept_o is combinational from lap_line_i; no backpressure, a dropped crossing is simply lost.
module rc_holdoff
  import race_pkg::*;
#(
  parameter int LAP_HOLDOFF = 32_500_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic lap_line_i,
  output logic accept_o
);

  localparam int CNT_W = clog2_min1(LAP_HOLDOFF);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LAP_HOLDOFF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign accept_o = en_i & lap_line_i & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (accept_o) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer: 3-2-1-GO countdown, start/stop strobes, qualified laps; all outputs registered.
// Optional RACE_FALSE_START_EN aborts the countdown on throttle and latches false_start.
module race_controller
  import race_pkg::*;
#(
  parameter int TICKS_PER_STEP = 65_000_000,
  parameter int LAPS           = 3,
  parameter int LAP_HOLDOFF    = 32_500_000
) (
  input  logic             pclk,
  input  logic             rst,
  race_controller_if.slave rc
);

  localparam int STEP_W = clog2_min1(TICKS_PER_STEP);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TICKS_PER_STEP - 1);
  localparam logic [LAP_W-1:0]  LAPS_L    = LAP_W'(LAPS);

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [1:0]         cd_q, cd_d;
  logic [LAP_W-1:0]   laps_q, laps_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               lapf_q, lapf_d;
  logic               fs_q, fs_d;
  logic               go_q, over_q;
  logic               req_prev_q;
  logic               req_edge;
  logic               fs_trip;
  logic               lap_accept;

  assign req_edge = rc.race_req & ~req_prev_q;

`ifdef RACE_FALSE_START_EN
  assign fs_trip = (state_q == COUNTDOWN) & rc.throttle;
`else
  logic unused_throttle;
  assign unused_throttle = rc.throttle;
  assign fs_trip = 1'b0;
`endif

  // Hold-off is kept clear outside RACING so the first racing cycle can accept a crossing.
  rc_holdoff #(.LAP_HOLDOFF(LAP_HOLDOFF)) u_holdoff (
    .pclk       (pclk),
    .rst        (rst),
    .en_i       ((state_q == RACING) && !rc.abort),
    .clr_i      (state_q != RACING),
    .lap_line_i (rc.lap_line),
    .accept_o   (lap_accept)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cd_d    = cd_q;
    laps_d  = laps_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    lapf_d  = 1'b0;
`ifdef RACE_FALSE_START_EN
    fs_d    = req_edge ? 1'b0 : fs_q;
`else
    fs_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rc.abort && req_edge) begin
          state_d = COUNTDOWN;
          cd_d    = CD_START;
          step_d  = '0;
          laps_d  = '0;
        end
      end
      COUNTDOWN: begin
        if (rc.abort || fs_trip) begin
          state_d = IDLE;
          cd_d    = 2'd0;
          laps_d  = '0;
          if (fs_trip) fs_d = 1'b1;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          if (cd_q == 2'd1) begin
            state_d = RACING;
            cd_d    = 2'd0;
            start_d = 1'b1;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      RACING: begin
        if (rc.abort) begin
          state_d = IDLE;
          stop_d  = 1'b1;
          laps_d  = '0;
        end else if (lap_accept) begin
          lapf_d = 1'b1;
          laps_d = laps_q + LAP_W'(1);
          if (laps_d == LAPS_L) begin
            stop_d  = 1'b1;
            state_d = FINISHED;
          end
        end
      end
      FINISHED: begin
        if (rc.abort) begin
          state_d = IDLE;
          laps_d  = '0;
        end else if (req_edge) begin
          state_d = COUNTDOWN;
          cd_d    = CD_START;
          step_d  = '0;
          laps_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      cd_q       <= 2'd0;
      laps_q     <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      lapf_q     <= 1'b0;
      fs_q       <= 1'b0;
      go_q       <= 1'b0;
      over_q     <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cd_q       <= cd_d;
      laps_q     <= laps_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      lapf_q     <= lapf_d;
      fs_q       <= fs_d;
      go_q       <= (state_d == RACING);
      over_q     <= (state_d == FINISHED);
      req_prev_q <= rc.race_req;
    end
  end

  assign rc.start        = start_q;
  assign rc.stop         = stop_q;
  assign rc.lap_finished = lapf_q;
  assign rc.countdown    = cd_q;
  assign rc.go_light     = go_q;
  assign rc.lap_count    = laps_q;
  assign rc.race_over    = over_q;
  assign rc.false_start  = fs_q;
  assign rc.state        = state_q;

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: directed scenarios plus randomized traffic against a timeline model.
module tb_race_controller;
  import race_pkg::*;

  localparam int TPS   = 4;
  localparam int NLAPS = 2;
  localparam int HOLD  = 8;
`ifdef RACE_FALSE_START_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  race_controller_if rc ();
  race_controller_if rc1 ();

  race_controller #(.TICKS_PER_STEP(TPS), .LAPS(NLAPS), .LAP_HOLDOFF(HOLD)) dut (
    .pclk (pclk),
    .rst  (rst),
    .rc   (rc.slave)
  );

  race_controller #(.TICKS_PER_STEP(TPS), .LAPS(1), .LAP_HOLDOFF(HOLD)) dut1 (
    .pclk (pclk),
    .rst  (rst),
    .rc   (rc1.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: state as a phase, countdown from elapsed time, hold-off from last accept time.
  int m_state = 0;
  int m_entry = 0;
  int m_laps  = 0;
  int m_last  = -1000000;
  bit m_prev  = 1'b0;
  bit m_fs    = 1'b0;
  bit e_start = 1'b0;
  bit e_stop  = 1'b0;
  bit e_lapf  = 1'b0;

  function automatic logic [1:0] e_cd();
    if (m_state == 1) return 2'(3 - (cyc - m_entry) / TPS);
    return 2'd0;
  endfunction

  task automatic model_update(input bit rs, input bit r, input bit a, input bit l, input bit th);
    bit rise;
    rise    = r && !m_prev;
    e_start = 1'b0;
    e_stop  = 1'b0;
    e_lapf  = 1'b0;
    if (!rs) begin
      m_state = 0;
      m_laps  = 0;
      m_fs    = 1'b0;
      m_prev  = 1'b0;
      return;
    end
    m_prev = r;
    if (FS_EN && rise) m_fs = 1'b0;
    case (m_state)
      0: if (!a && rise) begin m_state = 1; m_entry = cyc; m_laps = 0; end
      1: begin
        if (a) m_state = 0;
        else if (FS_EN && th) begin m_state = 0; m_fs = 1'b1; end
        else if (cyc - m_entry == 3 * TPS) begin m_state = 2; e_start = 1'b1; m_last = -1000000; end
      end
      2: begin
        if (a) begin m_state = 0; e_stop = 1'b1; m_laps = 0; end
        else if (l && ((cyc - 1) - m_last >= HOLD)) begin
          m_last = cyc - 1;
          m_laps++;
          e_lapf = 1'b1;
          if (m_laps == NLAPS) begin e_stop = 1'b1; m_state = 3; end
        end
      end
      default: begin
        if (a) begin m_state = 0; m_laps = 0; end
        else if (rise) begin m_state = 1; m_entry = cyc; m_laps = 0; end
      end
    endcase
  endtask

  task automatic step();
    bit rs, r, a, l, th;
    rs = rst; r = rc.race_req; a = rc.abort; l = rc.lap_line; th = rc.throttle;
    @(posedge pclk);
    #1;
    cyc++;
    model_update(rs, r, a, l, th);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rc.race_req = 0; rc.abort = 0; rc.lap_line = 0; rc.throttle = 0;
    rc1.race_req = 0; rc1.abort = 0; rc1.lap_line = 0; rc1.throttle = 0;
    repeat (3) step();
    checks++;
    if ({rc.start, rc.stop, rc.lap_finished, rc.go_light, rc.race_over, rc.false_start} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {rc.start, rc.stop, rc.lap_finished, rc.go_light, rc.race_over, rc.false_start});
    end
    checks++;
    if (rc.countdown !== 2'd0 || rc.lap_count !== 4'd0 || rc.state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: cd=%0d laps=%0d state=%0d want 0 0 0", rc.countdown, rc.lap_count, rc.state);
    end
    rst = 1'b1;
    step();
    checks++;
    if (rc.state !== 2'd0 || rc.countdown !== 2'd0 || rc.start !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d cd=%0d start=%0d want 0 0 0", rc.state, rc.countdown, rc.start);
    end
  endtask

  task automatic test_countdown();
    logic [1:0] want;
    rc.race_req = 1'b1;
    step();
    rc.race_req = 1'b0;
    for (int j = 0; j < 3 * TPS; j++) begin
      want = 2'(3 - j / TPS);
      checks++;
      if (rc.countdown !== want || rc.start !== 1'b0 || rc.state !== 2'd1) begin
        errors++;
        $display("FAIL countdown_%0d: cd=%0d start=%0d state=%0d want cd=%0d start=0 state=1",
                 j, rc.countdown, rc.start, rc.state, want);
      end
      step();
    end
    checks++;
    if (rc.start !== 1'b1 || rc.go_light !== 1'b1 || rc.state !== 2'd2 || rc.countdown !== 2'd0) begin
      errors++;
      $display("FAIL go: start=%0d go=%0d state=%0d cd=%0d want 1 1 2 0",
               rc.start, rc.go_light, rc.state, rc.countdown);
    end
  endtask

  task automatic test_laps();
    int nlapf = 0;
    bit want_l, want_s;
    for (int t = 0; t <= 12; t++) begin
      rc.lap_line = (t == 0 || t == 5 || t == 10);
      step();
      want_l = (t == 0 || t == 10);
      want_s = (t == 10);
      if (rc.lap_finished === 1'b1) nlapf++;
      checks++;
      if (rc.lap_finished !== want_l || rc.stop !== want_s) begin
        errors++;
        $display("FAIL lap_t%0d: lapf=%0d stop=%0d want %0d %0d", t, rc.lap_finished, rc.stop, want_l, want_s);
      end
      if (t == 10) begin
        checks++;
        if (rc.lap_count !== 4'd2 || rc.state !== 2'd3 || rc.race_over !== 1'b1 || rc.go_light !== 1'b0) begin
          errors++;
          $display("FAIL last_lap: laps=%0d state=%0d over=%0d go=%0d want 2 3 1 0",
                   rc.lap_count, rc.state, rc.race_over, rc.go_light);
        end
      end
    end
    rc.lap_line = 1'b0;
    checks++;
    if (nlapf != 2 || rc.state !== 2'd3 || rc.lap_count !== 4'd2) begin
      errors++;
      $display("FAIL lap_total: pulses=%0d state=%0d laps=%0d want 2 3 2", nlapf, rc.state, rc.lap_count);
    end
  endtask

  task automatic test_abort_lap();
    rc.race_req = 1'b1;
    step();
    rc.race_req = 1'b0;
    repeat (3 * TPS) step();
    rc.lap_line = 1'b1;
    step();
    rc.lap_line = 1'b0;
    repeat (HOLD) step();
    checks++;
    if (rc.lap_count !== 4'd1 || rc.state !== 2'd2) begin
      errors++;
      $display("FAIL abort_setup: laps=%0d state=%0d want 1 2", rc.lap_count, rc.state);
    end
    rc.lap_line = 1'b1;
    rc.abort = 1'b1;
    step();
    rc.lap_line = 1'b0;
    rc.abort = 1'b0;
    checks++;
    if (rc.stop !== 1'b1 || rc.state !== 2'd0 || rc.lap_count !== 4'd0 ||
        rc.lap_finished !== 1'b0 || rc.go_light !== 1'b0) begin
      errors++;
      $display("FAIL abort_lap: stop=%0d state=%0d laps=%0d lapf=%0d go=%0d want 1 0 0 0 0",
               rc.stop, rc.state, rc.lap_count, rc.lap_finished, rc.go_light);
    end
    step();
    checks++;
    if (rc.stop !== 1'b0 || rc.lap_finished !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: stop=%0d lapf=%0d want 0 0", rc.stop, rc.lap_finished);
    end
  endtask

  task automatic test_req_held();
    int starts = 0;
    rc.race_req = 1'b1;
    for (int t = 0; t < 60; t++) begin
      rc.lap_line = (t % 10 == 0);
      step();
      if (rc.start === 1'b1) starts++;
    end
    rc.lap_line = 1'b0;
    checks++;
    if (starts != 1 || rc.state !== 2'd3 || rc.lap_count !== 4'd2) begin
      errors++;
      $display("FAIL req_held: starts=%0d state=%0d laps=%0d want 1 3 2", starts, rc.state, rc.lap_count);
    end
    rc.race_req = 1'b0;
    step();
    rc.race_req = 1'b1;
    step();
    checks++;
    if (rc.state !== 2'd1 || rc.lap_count !== 4'd0 || rc.race_over !== 1'b0 || rc.countdown !== 2'd3) begin
      errors++;
      $display("FAIL restart: state=%0d laps=%0d over=%0d cd=%0d want 1 0 0 3",
               rc.state, rc.lap_count, rc.race_over, rc.countdown);
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    for (int i = 0; i < 20 && rc.countdown !== 2'd2; i++) step();
    checks++;
    if (rc.countdown !== 2'd2) begin
      errors++;
      $display("FAIL wait_cd2: cd=%0d want 2", rc.countdown);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({rc.start, rc.stop, rc.lap_finished, rc.go_light, rc.race_over, rc.false_start,
         rc.countdown, rc.lap_count, rc.state} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h want 0", {rc.start, rc.stop, rc.lap_finished, rc.go_light,
               rc.race_over, rc.false_start, rc.countdown, rc.lap_count, rc.state});
    end
    rst = 1'b1;
    rc.race_req = 1'b0;
    repeat (20) begin
      step();
      if (rc.start === 1'b1 || rc.stop === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || rc.state !== 2'd0) begin
      errors++;
      $display("FAIL reset_no_strobe: strobes=%0d state=%0d want 0 0", strobes, rc.state);
    end
  endtask

  task automatic test_false_start();
    int starts = 0;
    rc.race_req = 1'b1;
    step();
    rc.race_req = 1'b0;
    for (int i = 0; i < 20 && rc.countdown !== 2'd2; i++) step();
    rc.throttle = 1'b1;
    step();
    rc.throttle = 1'b0;
`ifdef RACE_FALSE_START_EN
    checks++;
    if (rc.state !== 2'd0 || rc.false_start !== 1'b1 || rc.countdown !== 2'd0) begin
      errors++;
      $display("FAIL false_start: state=%0d fs=%0d cd=%0d want 0 1 0", rc.state, rc.false_start, rc.countdown);
    end
    repeat (20) begin
      step();
      if (rc.start === 1'b1) starts++;
    end
    checks++;
    if (starts != 0 || rc.false_start !== 1'b1) begin
      errors++;
      $display("FAIL fs_sticky: starts=%0d fs=%0d want 0 1", starts, rc.false_start);
    end
    rc.race_req = 1'b1;
    step();
    rc.race_req = 1'b0;
    checks++;
    if (rc.false_start !== 1'b0 || rc.state !== 2'd1) begin
      errors++;
      $display("FAIL fs_clear: fs=%0d state=%0d want 0 1", rc.false_start, rc.state);
    end
`else
    checks++;
    if (rc.state !== 2'd1 || rc.false_start !== 1'b0) begin
      errors++;
      $display("FAIL throttle_ignored: state=%0d fs=%0d want 1 0", rc.state, rc.false_start);
    end
    repeat (20) begin
      step();
      if (rc.start === 1'b1) starts++;
    end
    checks++;
    if (starts != 1 || rc.state !== 2'd2) begin
      errors++;
      $display("FAIL throttle_race: starts=%0d state=%0d want 1 2", starts, rc.state);
    end
`endif
    rc.abort = 1'b1;
    step();
    rc.abort = 1'b0;
  endtask

  task automatic test_laps1();
    rc1.race_req = 1'b1;
    step();
    rc1.race_req = 1'b0;
    repeat (3 * TPS) step();
    checks++;
    if (rc1.start !== 1'b1 || rc1.state !== 2'd2) begin
      errors++;
      $display("FAIL laps1_go: start=%0d state=%0d want 1 2", rc1.start, rc1.state);
    end
    rc1.lap_line = 1'b1;
    step();
    rc1.lap_line = 1'b0;
    checks++;
    if (rc1.stop !== 1'b1 || rc1.lap_finished !== 1'b1 || rc1.lap_count !== 4'd1 ||
        rc1.state !== 2'd3 || rc1.race_over !== 1'b1) begin
      errors++;
      $display("FAIL laps1_end: stop=%0d lapf=%0d laps=%0d state=%0d over=%0d want 1 1 1 3 1",
               rc1.stop, rc1.lap_finished, rc1.lap_count, rc1.state, rc1.race_over);
    end
  endtask

  task automatic test_random();
    logic [13:0] obs, want;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) rc.race_req = ~rc.race_req;
      rc.abort    = ($urandom_range(0, 99) == 0);
      rc.lap_line = ($urandom_range(0, 3) == 0);
      rc.throttle = ($urandom_range(0, 39) == 0);
      step();
      obs  = {rc.start, rc.stop, rc.lap_finished, rc.countdown, rc.go_light,
              rc.lap_count, rc.race_over, rc.false_start, rc.state};
      want = {e_start, e_stop, e_lapf, e_cd(), (m_state == 2),
              4'(m_laps), (m_state == 3), m_fs, 2'(m_state)};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h want %h", cyc, obs, want);
      end
    end
    rst = 1'b1;
    rc.abort = 1'b0;
    rc.lap_line = 1'b0;
    rc.throttle = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_laps();
    test_abort_lap();
    test_req_held();
    test_reset_mid();
    test_false_start();
    test_laps1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
